// File: rtl/rgmii_pkg.sv
// Speed encodings and divider-counter sizing shared by the RGMII TX gearbox files.
package rgmii_pkg;

   localparam logic [1:0] SPEED_10M   = 2'b00;
   localparam logic [1:0] SPEED_100M  = 2'b01;
   localparam logic [1:0] SPEED_1000M = 2'b10;

   // Counter only has to reach the larger divider minus one.
   function automatic int cnt_width(input int div_a, input int div_b);
      int n;
      n = (div_a > div_b) ? div_a : div_b;
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rgmii_tx_clkdiv.sv
// Slot counter for 10M/100M: cnt/nib phase, DDR TX clock half-slot values and the byte strobe.
// An apply pulse restarts the phase under the newly selected speed.
module rgmii_tx_clkdiv
   import rgmii_pkg::*;
#(
   parameter int DIV_10M  = 50,
   parameter int DIV_100M = 5,
   parameter int CW       = cnt_width(DIV_10M, DIV_100M)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] speed_sel,
   input  logic       apply,
   input  logic [1:0] apply_speed,
   output logic       clk_d1,
   output logic       clk_d2,
   output logic       nib,
   output logic       strobe
);

   localparam logic [31:0] N10  = 32'(DIV_10M);
   localparam logic [31:0] N100 = 32'(DIV_100M);

   logic [CW-1:0] cnt_reg, cnt_next;
   logic          nib_reg, nib_next;
   logic          strobe_reg, strobe_next;
   logic [1:0]    speed_eff;
   logic [31:0]   n_eff, n_cur, cnt_w, cnt_next_w;
   logic [32:0]   half1, half2;

   always_comb begin
      speed_eff  = apply ? apply_speed : speed_sel;
      n_eff      = (speed_eff == SPEED_10M) ? N10 : N100;
      n_cur      = (speed_sel == SPEED_10M) ? N10 : N100;
      cnt_w      = 32'(cnt_reg);
      cnt_next   = cnt_reg;
      nib_next   = nib_reg;
      if (apply || speed_eff[1]) begin
         cnt_next = '0;
         nib_next = 1'b0;
      end else if (cnt_w == n_eff - 32'd1) begin
         cnt_next = '0;
         nib_next = ~nib_reg;
      end else begin
         cnt_next = cnt_reg + CW'(1);
      end
      cnt_next_w  = 32'(cnt_next);
      // Strobe is registered, so decode it from the state the counter is about to enter.
      strobe_next = speed_eff[1] | ((cnt_next_w == n_eff - 32'd1) & nib_next);
      half1       = {cnt_w, 1'b0};
      half2       = {cnt_w, 1'b1};
      clk_d1      = speed_sel[1] | (half1 < {1'b0, n_cur});
      clk_d2      = ~speed_sel[1] & (half2 < {1'b0, n_cur});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg    <= '0;
         nib_reg    <= 1'b0;
         strobe_reg <= 1'b0;
      end else begin
         cnt_reg    <= cnt_next;
         nib_reg    <= nib_next;
         strobe_reg <= strobe_next;
      end
   end

   assign nib    = nib_reg;
   assign strobe = strobe_reg;

endmodule

// File: rtl/rgmii_tx_gearbox.sv
// RGMII TX gearbox: byte capture, nibble/DDR split, TX_CTL encode, idle-deferred speed switch.
// Define RGMII_TX_FRAME_CNT_EN to add the frame_count/byte_count statistics ports.
module rgmii_tx_gearbox
   import rgmii_pkg::*;
#(
   parameter int         DIV_10M       = 50,
   parameter int         DIV_100M      = 5,
   parameter logic [1:0] DEFAULT_SPEED = SPEED_1000M
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  speed,
   input  logic [7:0]  mac_txd,
   input  logic        mac_tx_en,
   input  logic        mac_tx_er,
   output logic        mac_tx_clk_en,
   output logic        oddr_clk_d1,
   output logic        oddr_clk_d2,
   output logic [3:0]  oddr_txd_d1,
   output logic [3:0]  oddr_txd_d2,
   output logic        oddr_ctl_d1,
   output logic        oddr_ctl_d2,
   output logic [1:0]  speed_active,
   output logic        busy
`ifdef RGMII_TX_FRAME_CNT_EN
   ,
   output logic [31:0] frame_count,
   output logic [31:0] byte_count
`endif
);

   logic [1:0] speed_active_reg;
   logic [7:0] byte_reg;
   logic       en_reg, er_reg;
   logic       strobe, apply, div_nib, div_clk_d1, div_clk_d2;
   logic [1:0] div_clk;
   logic [3:0] txd_next [2];
   logic [1:0] ctl_next;
   logic       clk_d1_reg, clk_d2_reg, ctl_d1_reg, ctl_d2_reg;
   logic [3:0] txd_d1_reg, txd_d2_reg;

   // Switch only when the byte on the wire and the byte being offered are both idle.
   assign apply = strobe & ~en_reg & ~mac_tx_en & (speed != speed_active_reg);

   rgmii_tx_clkdiv #(
      .DIV_10M  (DIV_10M),
      .DIV_100M (DIV_100M)
   ) u_clkdiv (
      .clk         (clk),
      .rst         (rst),
      .speed_sel   (speed_active_reg),
      .apply       (apply),
      .apply_speed (speed),
      .clk_d1      (div_clk_d1),
      .clk_d2      (div_clk_d2),
      .nib         (div_nib),
      .strobe      (strobe)
   );

   assign div_clk = {div_clk_d2, div_clk_d1};

   // Half 0 is the rising-edge value, half 1 the falling-edge value.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_half
         assign txd_next[gi] = (speed_active_reg[1] ? (gi == 1) : div_nib) ?
                               byte_reg[7:4] : byte_reg[3:0];
         assign ctl_next[gi] = div_clk[gi] ? en_reg : (en_reg ^ er_reg);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         speed_active_reg <= DEFAULT_SPEED;
         byte_reg         <= '0;
         en_reg           <= 1'b0;
         er_reg           <= 1'b0;
         clk_d1_reg       <= 1'b1;
         clk_d2_reg       <= 1'b0;
         txd_d1_reg       <= '0;
         txd_d2_reg       <= '0;
         ctl_d1_reg       <= 1'b0;
         ctl_d2_reg       <= 1'b0;
      end else begin
         if (strobe) begin
            byte_reg <= mac_txd;
            en_reg   <= mac_tx_en;
            er_reg   <= mac_tx_er;
         end
         if (apply) begin
            speed_active_reg <= speed;
         end
         clk_d1_reg <= div_clk[0];
         clk_d2_reg <= div_clk[1];
         txd_d1_reg <= txd_next[0];
         txd_d2_reg <= txd_next[1];
         ctl_d1_reg <= ctl_next[0];
         ctl_d2_reg <= ctl_next[1];
      end
   end

`ifdef RGMII_TX_FRAME_CNT_EN
   logic [31:0] frame_count_reg, byte_count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_count_reg <= '0;
         byte_count_reg  <= '0;
      end else if (strobe) begin
         if (en_reg && !mac_tx_en) begin
            frame_count_reg <= frame_count_reg + 32'd1;
         end
         if (mac_tx_en) begin
            byte_count_reg <= byte_count_reg + 32'd1;
         end
      end
   end

   assign frame_count = frame_count_reg;
   assign byte_count  = byte_count_reg;
`endif

   assign mac_tx_clk_en = strobe;
   assign oddr_clk_d1   = clk_d1_reg;
   assign oddr_clk_d2   = clk_d2_reg;
   assign oddr_txd_d1   = txd_d1_reg;
   assign oddr_txd_d2   = txd_d2_reg;
   assign oddr_ctl_d1   = ctl_d1_reg;
   assign oddr_ctl_d2   = ctl_d2_reg;
   assign speed_active  = speed_active_reg;
   assign busy          = en_reg;

endmodule

// File: tb/tb_rgmii_tx_gearbox.sv
// Randomised bench for rgmii_tx_gearbox against a slot-arithmetic reference model.
`timescale 1ns/1ps
module tb_rgmii_tx_gearbox;
   import rgmii_pkg::*;

   localparam int         DIV_10M       = 50;
   localparam int         DIV_100M      = 5;
   localparam logic [1:0] DEFAULT_SPEED = SPEED_1000M;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] speed;
   logic [7:0] mac_txd;
   logic       mac_tx_en, mac_tx_er;
   logic       mac_tx_clk_en;
   logic       oddr_clk_d1, oddr_clk_d2, oddr_ctl_d1, oddr_ctl_d2;
   logic [3:0] oddr_txd_d1, oddr_txd_d2;
   logic [1:0] speed_active;
   logic       busy;
`ifdef RGMII_TX_FRAME_CNT_EN
   logic [31:0] frame_count, byte_count;
`endif

   always #4 clk = ~clk;

   rgmii_tx_gearbox #(
      .DIV_10M       (DIV_10M),
      .DIV_100M      (DIV_100M),
      .DEFAULT_SPEED (DEFAULT_SPEED)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .speed         (speed),
      .mac_txd       (mac_txd),
      .mac_tx_en     (mac_tx_en),
      .mac_tx_er     (mac_tx_er),
      .mac_tx_clk_en (mac_tx_clk_en),
      .oddr_clk_d1   (oddr_clk_d1),
      .oddr_clk_d2   (oddr_clk_d2),
      .oddr_txd_d1   (oddr_txd_d1),
      .oddr_txd_d2   (oddr_txd_d2),
      .oddr_ctl_d1   (oddr_ctl_d1),
      .oddr_ctl_d2   (oddr_ctl_d2),
      .speed_active  (speed_active),
      .busy          (busy)
`ifdef RGMII_TX_FRAME_CNT_EN
      ,
      .frame_count   (frame_count),
      .byte_count    (byte_count)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: phase = cycles since last restart; one byte occupies 2N cycles.
   logic [1:0]  m_speed;
   int          m_phase;
   logic        m_stb, m_en, m_er;
   logic [7:0]  m_byte;
   logic        m_clk1, m_clk2, m_ctl1, m_ctl2;
   logic [3:0]  m_txd1, m_txd2;
   logic [31:0] m_frames, m_bytes;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic int div_of(input logic [1:0] s);
      return (s == SPEED_10M) ? DIV_10M : DIV_100M;
   endfunction

   task automatic model_reset();
      m_speed = DEFAULT_SPEED; m_phase = 0; m_stb = 1'b0;
      m_byte = 8'h00; m_en = 1'b0; m_er = 1'b0;
      m_clk1 = 1'b1; m_clk2 = 1'b0; m_txd1 = 4'h0; m_txd2 = 4'h0;
      m_ctl1 = 1'b0; m_ctl2 = 1'b0; m_frames = 32'd0; m_bytes = 32'd0;
   endtask

   task automatic model_edge();
      int   n;
      int   c;
      logic nib;
      logic do_apply;
      n = div_of(m_speed);
      if (m_speed[1]) begin
         m_clk1 = 1'b1; m_clk2 = 1'b0;
         m_txd1 = m_byte[3:0]; m_txd2 = m_byte[7:4];
      end else begin
         c      = m_phase % n;
         nib    = ((m_phase / n) % 2) == 1;
         m_clk1 = (2 * c) < n;
         m_clk2 = (2 * c + 1) < n;
         m_txd1 = nib ? m_byte[7:4] : m_byte[3:0];
         m_txd2 = m_txd1;
      end
      m_ctl1 = m_clk1 ? m_en : (m_en ^ m_er);
      m_ctl2 = m_clk2 ? m_en : (m_en ^ m_er);
      do_apply = 1'b0;
      if (m_stb) begin
         do_apply = !m_en && !mac_tx_en && (speed != m_speed);
         if (mac_tx_en) m_bytes++;
         if (m_en && !mac_tx_en) m_frames++;
         m_byte = mac_txd; m_en = mac_tx_en; m_er = mac_tx_er;
      end
      if (do_apply) begin
         m_speed = speed;
         m_phase = 0;
      end else begin
         m_phase++;
      end
      n     = div_of(m_speed);
      m_stb = m_speed[1] ? 1'b1 : ((m_phase % (2 * n)) == (2 * n - 1));
   endtask

   task automatic check_outputs();
      check("clk",    32'({oddr_clk_d1, oddr_clk_d2}), 32'({m_clk1, m_clk2}));
      check("txd",    32'({oddr_txd_d1, oddr_txd_d2}), 32'({m_txd1, m_txd2}));
      check("ctl",    32'({oddr_ctl_d1, oddr_ctl_d2}), 32'({m_ctl1, m_ctl2}));
      check("strobe", 32'(mac_tx_clk_en), 32'(m_stb));
      check("busy",   32'(busy), 32'(m_en));
      check("speed",  32'(speed_active), 32'(m_speed));
`ifdef RGMII_TX_FRAME_CNT_EN
      check("frames", frame_count, m_frames);
      check("bytes",  byte_count, m_bytes);
`endif
   endtask

   task automatic reset_checks();
      check("rst_clk_d1", 32'(oddr_clk_d1), 32'd1);
      check("rst_clk_d2", 32'(oddr_clk_d2), 32'd0);
      check("rst_txd",    32'({oddr_txd_d1, oddr_txd_d2}), 32'd0);
      check("rst_ctl",    32'({oddr_ctl_d1, oddr_ctl_d2}), 32'd0);
      check("rst_strobe", 32'(mac_tx_clk_en), 32'd0);
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_speed",  32'(speed_active), 32'(DEFAULT_SPEED));
   endtask

   task automatic step();
      if (!rst) model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   // Hold the byte on the MAC side until the model says it has been captured.
   task automatic send_byte(input logic [7:0] d, input logic en, input logic er);
      logic taken;
      int   guard;
      mac_txd = d; mac_tx_en = en; mac_tx_er = er;
      taken = 1'b0;
      guard = 0;
      while (!taken && guard < 4 * DIV_10M + 8) begin
         taken = m_stb;
         step();
         guard++;
      end
      if (!taken) begin
         n_checks++;
         $display("FAIL byte_wait: no byte strobe within %0d cycles", guard);
      end
   endtask

   task automatic wait_apply();
      int guard;
      guard = 0;
      while (m_speed != speed && guard < 6) begin
         send_byte(8'($urandom), 1'b0, 1'b0);
         guard++;
      end
      check("apply_wait", 32'(speed_active), 32'(speed));
   endtask

   task automatic send_frame(input int len, input logic first_set, input logic [7:0] first,
                             input logic er_all);
      for (int i = 0; i < len; i++) begin
         send_byte((i == 0 && first_set) ? first : 8'($urandom), 1'b1, er_all);
      end
      send_byte(8'($urandom), 1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] t1_bytes [3];
      logic       stb_before;
      int         k;
      logic [31:0] fc0, bc0;
      t1_bytes[0] = 8'h55; t1_bytes[1] = 8'hD5; t1_bytes[2] = 8'hA3;
      fc0 = 32'd0; bc0 = 32'd0;

      rst = 1'b1; speed = SPEED_1000M;
      mac_txd = 8'h00; mac_tx_en = 1'b0; mac_tx_er = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_checks();
      check_outputs();
      rst = 1'b0;

      // Gigabit preamble/SFD-style bytes
      for (int i = 0; i < 3; i++) send_byte(t1_bytes[i], 1'b1, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      step();
      $display("frame t1: 1000M bytes 55 D5 A3");

      speed = SPEED_100M;
      wait_apply();
      send_frame(4, 1'b1, 8'h3C, 1'b0);
      $display("frame t2: 100M first byte 3C len 4");

      speed = SPEED_10M;
      wait_apply();
      send_frame(2, 1'b0, 8'h00, 1'b1);
      $display("frame t3: 10M len 2 with tx_er");

      // Speed request raised mid-frame must wait for an idle boundary.
      speed = SPEED_1000M;
      wait_apply();
      for (int i = 0; i < 8; i++) begin
         if (i == 3) speed = SPEED_10M;
         send_byte(8'($urandom), 1'b1, 1'b0);
      end
      check("defer_busy", 32'(speed_active), 32'(SPEED_1000M));
      mac_txd = 8'h00; mac_tx_en = 1'b0; mac_tx_er = 1'b0;
      k = 0;
      while (speed_active == SPEED_1000M && k < 20) begin
         step();
         k++;
      end
      check("defer_apply", 32'(speed_active), 32'(SPEED_10M));
      k = 0;
      stb_before = 1'b0;
      while (!stb_before && k < 4 * DIV_10M) begin
         stb_before = mac_tx_clk_en;
         step();
         k++;
      end
      check("first_byte_10m", 32'(k), 32'(2 * DIV_10M));
      $display("frame t4: deferred 1000M->10M switch, first capture after %0d cycles", k);

      // Async reset in the middle of a 100M frame.
      speed = SPEED_100M;
      wait_apply();
      send_byte(8'($urandom), 1'b1, 1'b0);
      send_byte(8'($urandom), 1'b1, 1'b0);
      mac_txd = 8'($urandom);
      step(); step(); step();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      reset_checks();
      check_outputs();
      mac_txd = 8'h00; mac_tx_en = 1'b0; mac_tx_er = 1'b0;
      step(); step();
      rst = 1'b0;
      wait_apply();
      send_frame(2, 1'b0, 8'h00, 1'b0);
      $display("frame t5: reset mid-frame at 100M, restarted");

      speed = SPEED_1000M;
      wait_apply();
`ifdef RGMII_TX_FRAME_CNT_EN
      fc0 = frame_count;
      bc0 = byte_count;
`endif
      send_frame(64, 1'b0, 8'h00, 1'b0);
      send_frame(64, 1'b0, 8'h00, 1'b0);
`ifdef RGMII_TX_FRAME_CNT_EN
      check("frame_delta", frame_count - fc0, 32'd2);
      check("byte_delta",  byte_count - bc0, 32'd128);
`endif
      $display("frame t6: two 64-byte frames at 1000M");

      for (int f = 0; f < 14; f++) begin
         int len;
         int idle;
         len  = $urandom_range(1, 6);
         idle = $urandom_range(1, 3);
         speed = 2'($urandom_range(0, 3));
         for (int i = 0; i < idle; i++) send_byte(8'($urandom), 1'b0, 1'b0);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) speed = 2'($urandom_range(0, 3));
            send_byte(8'($urandom), 1'b1, ($urandom_range(0, 5) == 0));
         end
         send_byte(8'($urandom), 1'b0, 1'b0);
         $display("frame r%0d: speed_active=%0b len=%0d", f, speed_active, len);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
